// File: rtl/adc_capture_trigger_ctrl.sv
// adc_capture_trigger_ctrl: decimating, prefill-gated trigger front end for the capture FIFO write port
module adc_capture_trigger_ctrl #(
  parameter int DATA_WIDTH  = 10,
  parameter int DECIM_WIDTH = 16,
  parameter int PRE_WIDTH   = 32
) (
  input  logic                   wr_clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  adc_data,
  input  logic                   arm,
  input  logic [1:0]             trig_mode,
  input  logic [DATA_WIDTH-1:0]  trig_level,
  input  logic                   ext_trigger,
  input  logic [DECIM_WIDTH-1:0] decimate,
  input  logic [PRE_WIDTH-1:0]   presamples,
  input  logic                   wr_done,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_ce,
  output logic                   wr_trigger,
  output logic                   armed,
  output logic                   capture_done
);
  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, CAPTURE, DONE} state_t;
  localparam logic [PRE_WIDTH-1:0]   ONE_P = 1;
  localparam logic [DECIM_WIDTH-1:0] ONE_D = 1;
  state_t state, nxt;
  logic [1:0] mode;
  logic [DATA_WIDTH-1:0] lvl, prev;
  logic [DECIM_WIDTH-1:0] decim, dcnt;
  logic [PRE_WIDTH-1:0] pre, pcnt;
  logic latch, start, strobe, det, hit, fire;
  always_comb begin
    start  = (state == IDLE || state == DONE) && arm;
    strobe = dcnt == '0 && ((state == PREFILL && pre != '0) || state == WAIT_TRIG ||
             (state == CAPTURE && !wr_done));
    det    = mode == 2'b00 ? (prev < lvl && adc_data >= lvl) :
             mode == 2'b01 ? (prev >= lvl && adc_data < lvl) :
             mode == 2'b10 ? ext_trigger : 1'b1;
    hit    = latch | det;
    fire   = state == WAIT_TRIG && strobe && hit;
    nxt    = start ? PREFILL :
             (state == PREFILL && (pre == '0 || (strobe && pcnt + ONE_P == pre))) ? WAIT_TRIG :
             fire ? CAPTURE :
             (state == CAPTURE && wr_done) ? DONE : state;
  end
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_data      <= '0;
      wr_ce        <= 1'b0;
      wr_trigger   <= 1'b0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      mode         <= '0;
      lvl          <= '0;
      prev         <= '0;
      decim        <= '0;
      dcnt         <= '0;
      pre          <= '0;
      pcnt         <= '0;
      latch        <= 1'b0;
    end else begin
      state        <= nxt;
      prev         <= adc_data;
      wr_ce        <= strobe;
      wr_trigger   <= fire;
      armed        <= nxt == PREFILL || nxt == WAIT_TRIG;
      capture_done <= nxt == DONE;
      if (strobe) wr_data <= adc_data;
      if (start) begin
        mode  <= trig_mode;
        lvl   <= trig_level;
        decim <= decimate;
        pre   <= presamples;
        dcnt  <= '0;
        pcnt  <= '0;
        latch <= 1'b0;
      end else begin
        if (state inside {PREFILL, WAIT_TRIG, CAPTURE}) dcnt <= dcnt == decim ? '0 : dcnt + ONE_D;
        if (state == PREFILL && strobe) pcnt <= pcnt + ONE_P;
        // detections between strobes are held until the next strobe carries the marker
        if (state == WAIT_TRIG) latch <= hit && !fire;
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_trigger_ctrl.sv
// tb_adc_capture_trigger_ctrl: directed checks of prefill, trigger modes, decimation, done and reset
module tb_adc_capture_trigger_ctrl;
  logic wr_clk = 0, rst = 1, arm = 0, ext_trigger = 0, wr_done = 0;
  logic [9:0] adc_data = 0, trig_level = 0, wr_data;
  logic [1:0] trig_mode = 0;
  logic [15:0] decimate = 0;
  logic [31:0] presamples = 0;
  logic wr_ce, wr_trigger, armed, capture_done;
  int checks = 0, errors = 0;
  adc_capture_trigger_ctrl dut (
    .wr_clk(wr_clk), .rst(rst), .adc_data(adc_data), .arm(arm), .trig_mode(trig_mode),
    .trig_level(trig_level), .ext_trigger(ext_trigger), .decimate(decimate),
    .presamples(presamples), .wr_done(wr_done), .wr_data(wr_data), .wr_ce(wr_ce),
    .wr_trigger(wr_trigger), .armed(armed), .capture_done(capture_done)
  );
  always #5 wr_clk = ~wr_clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge wr_clk);
    @(negedge wr_clk);
  endtask
  task automatic do_arm(input logic [1:0] m, input int lv, input int dc, input int pr);
    trig_mode = m; trig_level = 10'(lv); decimate = 16'(dc); presamples = pr;
    arm = 1; adc_data = 0;
    cyc;
    arm = 0;
    chk("arm_armed", armed, 1);
    chk("arm_done_clr", capture_done, 0);
    chk("arm_no_ce", wr_ce, 0);
  endtask
  initial begin
    @(negedge wr_clk);
    chk("rst_ce", wr_ce, 0);
    chk("rst_trig", wr_trigger, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", capture_done, 0);
    cyc;
    rst = 0;
    cyc;
    chk("idle_ce", wr_ce, 0);
    // immediate trigger after 17 prefill strobes
    do_arm(2'b11, 0, 0, 17);
    for (int i = 0; i <= 17; i++) begin
      adc_data = 10'(234 + i);
      cyc;
      chk("t1_ce", wr_ce, 1);
      chk("t1_data", wr_data, 234 + i);
      chk("t1_trig", wr_trigger, i == 17);
      chk("t1_armed", armed, i < 17);
    end
    adc_data = 252;
    cyc;
    chk("cap_ce", wr_ce, 1);
    chk("cap_data", wr_data, 252);
    chk("cap_trig_once", wr_trigger, 0);
    arm = 1; adc_data = 253;
    cyc;
    arm = 0;
    chk("cap_arm_ign_ce", wr_ce, 1);
    chk("cap_arm_ign_armed", armed, 0);
    wr_done = 1;
    cyc;
    wr_done = 0;
    chk("done_ce", wr_ce, 0);
    chk("done_flag", capture_done, 1);
    cyc;
    chk("done_ce2", wr_ce, 0);
    chk("done_flag2", capture_done, 1);
    chk("done_armed", armed, 0);
    // rising level, decimate 3, config changed after arm must not matter
    do_arm(2'b00, 289, 3, 4);
    trig_level = 0; decimate = 0; presamples = 1; trig_mode = 2'b11;
    for (int j = 0; j <= 60; j++) begin
      adc_data = 10'(234 + j);
      cyc;
      chk("t2_ce", wr_ce, j % 4 == 0);
      chk("t2_trig", wr_trigger, j == 56);
      if (j % 4 == 0) chk("t2_data", wr_data, 234 + j);
    end
    wr_done = 1;
    cyc;
    wr_done = 0;
    chk("t2_done", capture_done, 1);
    // crossing during prefill is ignored
    do_arm(2'b00, 100, 0, 10);
    for (int j = 0; j <= 16; j++) begin
      adc_data = (j < 5) ? 10'd50 : (j < 13) ? 10'd150 : (j < 15) ? 10'd50 : 10'd150;
      cyc;
      chk("t3_ce", wr_ce, 1);
      chk("t3_trig", wr_trigger, j == 15);
    end
    wr_done = 1;
    cyc;
    wr_done = 0;
    // falling level
    do_arm(2'b01, 512, 0, 1);
    for (int j = 0; j <= 3; j++) begin
      adc_data = (j < 2) ? 10'd600 : 10'd500;
      cyc;
      chk("t4_trig", wr_trigger, j == 2);
    end
    chk("t4_data", wr_data, 500);
    wr_done = 1;
    cyc;
    wr_done = 0;
    // external pulse between strobes
    do_arm(2'b10, 0, 7, 1);
    for (int j = 0; j <= 16; j++) begin
      adc_data = 10'(700 + j);
      ext_trigger = j == 10;
      cyc;
      chk("t5_ce", wr_ce, j % 8 == 0);
      chk("t5_trig", wr_trigger, j == 16);
      if (j % 8 == 0) chk("t5_data", wr_data, 700 + j);
    end
    ext_trigger = 0;
    // asynchronous reset mid-capture
    #2 rst = 1;
    #1;
    chk("arst_ce", wr_ce, 0);
    chk("arst_trig", wr_trigger, 0);
    chk("arst_data", wr_data, 0);
    cyc;
    rst = 0;
    for (int j = 0; j < 4; j++) begin
      cyc;
      chk("post_rst_ce", wr_ce, 0);
      chk("post_rst_armed", armed, 0);
      chk("post_rst_done", capture_done, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
